// File: rtl/inert_chan_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module : inert_disp_pkg
// Brief  : FSM state encodings and fixed LED patterns for the channel display.
// Rev    : 1.0
// ============================================================================
package inert_disp_pkg;

    typedef logic [1:0] disp_state_t;

    localparam disp_state_t ST_IDLE = 2'd0;
    localparam disp_state_t ST_CAL  = 2'd1;
    localparam disp_state_t ST_SHOW = 2'd2;
    localparam disp_state_t ST_ERR  = 2'd3;

    // Sliced down to LED_W by the user; wide enough for any legal LED_W.
    localparam logic [31:0] LED_CAL = 32'h0000_0001;
    localparam logic [31:0] LED_ERR = 32'hFFFF_FFFF;

endpackage : inert_disp_pkg
`default_nettype wire

// File: rtl/inert_chan_disp_if.sv
`default_nettype none
// ============================================================================
// Module : inert_chan_disp_if
// Brief  : Control, sample and display signals between inertial side and display.
// Rev    : 1.0
// ============================================================================
interface inert_chan_disp_if #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 16,
    parameter int LED_W  = 8
);
    localparam int CH_W = $clog2(NUM_CH);

    logic                     next;
    logic                     cal_done;
    logic                     vld;
    logic [NUM_CH*DATA_W-1:0] data;
    logic                     strt_cal;
    logic [LED_W-1:0]         LED;
    logic [CH_W-1:0]          chan;
    logic                     cal_err;

    modport master (
        output next, cal_done, vld, data,
        input  strt_cal, LED, chan, cal_err
    );

    modport slave (
        input  next, cal_done, vld, data,
        output strt_cal, LED, chan, cal_err
    );

endinterface : inert_chan_disp_if
`default_nettype wire

// File: rtl/inert_chan_disp_win_sat.sv
`default_nettype none
// ============================================================================
// Module : win_sat
// Brief  : Extracts an LED_W window from a signed word, saturating on overflow.
// Rev    : 1.0
// ============================================================================
module win_sat #(
    parameter int DATA_W  = 16,
    parameter int LED_W   = 8,
    parameter int LSB_SEL = 1
) (
    input  wire logic [DATA_W-1:0] i_word,
    output logic      [LED_W-1:0]  o_led
);
    localparam int HI = LSB_SEL + LED_W - 1;

    localparam logic [LED_W-1:0] c_SAT_MAX = {1'b0, {(LED_W-1){1'b1}}};
    localparam logic [LED_W-1:0] c_SAT_MIN = {1'b1, {(LED_W-1){1'b0}}};

    // Window top bit plus everything above it must all agree with the sign.
    logic [DATA_W-1-HI:0] w_upper;
    logic                 w_fits;

    assign w_upper = i_word[DATA_W-1:HI];
    assign w_fits  = (&w_upper) | ~(|w_upper);

    always_comb begin
        o_led = i_word[HI:LSB_SEL];
        if (!w_fits) begin
            o_led = i_word[DATA_W-1] ? c_SAT_MIN : c_SAT_MAX;
        end
    end

    generate
        if (LSB_SEL > 0) begin : g_trunc
            logic w_unused_lsb;
            assign w_unused_lsb = ^i_word[LSB_SEL-1:0];
        end
    endgenerate

endmodule : win_sat
`default_nettype wire

// File: rtl/inert_chan_disp.sv
`default_nettype none
// ============================================================================
// Module : inert_chan_disp
// Brief  : Calibration-gated display of one inertial channel on LEDs.
//          Optional auto-scroll through channels: define DISP_AUTO_SCROLL_EN.
// Rev    : 1.0
// ============================================================================
module inert_chan_disp
    import inert_disp_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int DATA_W     = 16,
    parameter int LED_W      = 8,
    parameter int LSB_SEL    = 1,
    parameter int CAL_TMO    = 2**24,
    parameter int SCROLL_CYC = 25_000_000
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    inert_chan_disp_if.slave  bus
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = (CAL_TMO > 2) ? $clog2(CAL_TMO) : 1;

    localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(CAL_TMO - 1);
    localparam logic [CH_W-1:0]  c_CH_LAST  = CH_W'(NUM_CH - 1);

    disp_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CH_W-1:0]  r_chan, w_chan_nxt;
    logic [LED_W-1:0] r_led, w_led_nxt;
    logic             w_strt;
    logic             w_adv;
    logic [DATA_W-1:0] w_sel;
    logic [LED_W-1:0]  w_win;

`ifdef DISP_AUTO_SCROLL_EN
    localparam int SCR_W = (SCROLL_CYC > 2) ? $clog2(SCROLL_CYC) : 1;
    localparam logic [SCR_W-1:0] c_SCR_LAST = SCR_W'(SCROLL_CYC - 1);

    logic [SCR_W-1:0] r_scroll;
    logic             w_scroll_hit;

    assign w_scroll_hit = (r_state == ST_SHOW) && (r_scroll == c_SCR_LAST);
    assign w_adv        = bus.next || w_scroll_hit;

    // Free-runs only in SHOW; a manual step restarts the period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scroll <= '0;
        end else if (r_state != ST_SHOW || bus.next || w_scroll_hit) begin
            r_scroll <= '0;
        end else begin
            r_scroll <= r_scroll + 1'b1;
        end
    end
`else
    assign w_adv = bus.next;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_chan_nxt  = r_chan;
        w_strt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.next) begin
                    w_strt      = 1'b1;
                    w_state_nxt = ST_CAL;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CAL: begin
                if (bus.cal_done) begin
                    w_state_nxt = ST_SHOW;
                    w_chan_nxt  = '0;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_TMO_LAST) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_SHOW: begin
                if (w_adv) begin
                    w_chan_nxt = (r_chan == c_CH_LAST) ? '0 : r_chan + 1'b1;
                end
            end
            ST_ERR: begin
                if (bus.next) begin
                    w_strt      = 1'b1;
                    w_state_nxt = ST_CAL;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_chan_nxt  = '0;
            end
        endcase
    end

    // Select by the upcoming channel so a step and a sample in one cycle show the new channel.
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_chan_nxt == CH_W'(k)) begin
                w_sel = bus.data[k*DATA_W +: DATA_W];
            end
        end
    end

    win_sat #(
        .DATA_W  (DATA_W),
        .LED_W   (LED_W),
        .LSB_SEL (LSB_SEL)
    ) u_win_sat (
        .i_word (w_sel),
        .o_led  (w_win)
    );

    always_comb begin
        w_led_nxt = r_led;
        case (w_state_nxt)
            ST_IDLE: w_led_nxt = '0;
            ST_CAL:  w_led_nxt = LED_CAL[LED_W-1:0];
            ST_ERR:  w_led_nxt = LED_ERR[LED_W-1:0];
            ST_SHOW: begin
                if (r_state != ST_SHOW || w_chan_nxt != r_chan || bus.vld) begin
                    w_led_nxt = w_win;
                end
            end
            default: w_led_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_chan  <= '0;
            r_led   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_chan  <= w_chan_nxt;
            r_led   <= w_led_nxt;
        end
    end

    assign bus.strt_cal = w_strt;
    assign bus.LED      = r_led;
    assign bus.chan     = r_chan;
    assign bus.cal_err  = (r_state == ST_ERR);

endmodule : inert_chan_disp
`default_nettype wire

// File: doc/inert_chan_disp.md
INERT_CHAN_DISP -- requirements
Module: inert_chan_disp

Interface
REQ-001 Parameter NUM_CH, 3, number of displayable data channels (2..8).
REQ-002 Parameter DATA_W, 16, signed width of each channel word.
REQ-003 Parameter LED_W, 8, LED output width (LED_W < DATA_W).
REQ-004 Parameter LSB_SEL, 1, lowest channel bit shown on LED[0] (LSB_SEL+LED_W <= DATA_W).
REQ-005 Parameter CAL_TMO, 2**24, calibration timeout in clk cycles.
REQ-006 Parameter SCROLL_CYC, 25_000_000, auto-scroll period in clk cycles.
REQ-007 clk  in  1  system clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-008 rst_n  in  1  asynchronous active-low reset, already synchronised upstream.
REQ-009 next  in  1  single-cycle pulse from button-release detector.
REQ-010 cal_done  in  1  calibration-complete pulse from inertial interface.
REQ-011 vld  in  1  new-sample strobe from inertial interface.
REQ-012 data  in  NUM_CH*DATA_W  channel k at data[k*DATA_W +: DATA_W], signed.
REQ-013 strt_cal  out  1  one-cycle calibration request.
REQ-014 LED  out  LED_W  registered display value.
REQ-015 chan  out  $clog2(NUM_CH)  index of displayed channel.
REQ-016 cal_err  out  1  high while in ERR state.

Function
REQ-017 The FSM SHALL have states IDLE, CAL, SHOW, ERR.
REQ-018 IDLE: next SHALL assert strt_cal combinationally in the same cycle and move to CAL; LED = 0.
REQ-019 CAL: LED SHALL be {0..., 1'b1}; the timeout counter SHALL increment each cycle from 0.
REQ-020 CAL: cal_done SHALL move to SHOW with chan = 0; next SHALL be ignored.
REQ-021 CAL: counter reaching CAL_TMO-1 without cal_done SHALL move to ERR; simultaneous cal_done wins.
REQ-022 ERR: LED SHALL be all ones, cal_err = 1; next SHALL pulse strt_cal, clear the counter, and return to CAL.
REQ-023 SHOW: next SHALL increment chan, wrapping NUM_CH-1 -> 0.
REQ-024 SHOW: LED SHALL load the selected channel window one cycle after vld, and one cycle after any chan change regardless of vld.
REQ-025 Window: bits below LSB_SEL SHALL be truncated; if bits above LSB_SEL+LED_W-1 are not sign extension, LED SHALL saturate to signed max 0x7F.. or min 0x80.. (LED_W scale).
REQ-026 next coincident with vld in SHOW: LED SHALL load the new channel value.

Reset
REQ-027 Reset SHALL force state IDLE, chan 0, LED 0, strt_cal 0, cal_err 0, all counters 0, immediately and asynchronously, including mid-CAL or mid-SHOW.

Configuration
REQ-028 With DISP_AUTO_SCROLL_EN defined, SHOW SHALL also advance chan every SCROLL_CYC cycles; next SHALL advance chan and restart the scroll counter.
REQ-029 Without DISP_AUTO_SCROLL_EN, no scroll counter SHALL exist and chan SHALL change only on next.

Structure
REQ-030 Package inert_disp_pkg SHALL hold the state enum and the LED_CAL/LED_ERR pattern constants.
REQ-031 Sub-module win_sat SHALL implement the combinational window extraction with saturation (REQ-025).

Verification
REQ-032 Reset, then next -> strt_cal high exactly 1 cycle, LED=0x01; cal_done -> chan=0, state SHOW.
REQ-033 SHOW with data ch1=16'h00A4, next then vld -> chan=1, LED=0x52; ch1=16'h0400 -> LED=0x7F; ch1=16'hF800 -> LED=0x80.
REQ-034 Three next pulses in SHOW (NUM_CH=3) -> chan 1,2,0.
REQ-035 CAL_TMO=16, no cal_done -> ERR after 16 cycles, LED=0xFF, cal_err=1; next -> strt_cal, CAL.
REQ-036 cal_done on timeout cycle -> SHOW, cal_err stays 0; rst_n low mid-SHOW -> all outputs 0 same cycle.
REQ-037 DISP_AUTO_SCROLL_EN, SCROLL_CYC=10 -> chan advances every 10 cycles; next at cycle 5 restarts count.
